// File: rtl/dbg_pkg.sv
// Shared definitions for the debug memory bridge: opcodes, status bit positions, FSM states.
package dbg_pkg;

    localparam logic [7:0] DBGOP_NOOP         = 8'h00;
    localparam logic [7:0] DBGOP_HALT         = 8'h01;
    localparam logic [7:0] DBGOP_RESUME       = 8'h02;
    localparam logic [7:0] DBGOP_RESET        = 8'h03;
    localparam logic [7:0] DBGOP_READ         = 8'h04;
    localparam logic [7:0] DBGOP_WRITE        = 8'h05;
    localparam logic [7:0] DBGOP_CLEAR_STATUS = 8'h08;
    localparam logic [7:0] DBGOP_STORE_ADDR   = 8'h80;
    localparam logic [7:0] DBGOP_STORE_DATA   = 8'h81;
    localparam logic [7:0] DBGOP_SELECT_CHAN  = 8'h82;
    localparam logic [7:0] DBGOP_STORE_FLAGS  = 8'h84;

    localparam int unsigned STAT_HALT     = 0;
    localparam int unsigned STAT_BUSY     = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_TIMEOUT  = 3;
    localparam int unsigned STAT_BAD_CHAN = 4;
    localparam int unsigned STAT_W        = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/dbg_pulse_gen.sv
// Registered pulse of programmable length; a new start restarts the count.
module dbg_pulse_gen #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             pulse
);

    logic [LEN_W-1:0] cnt_q;

    // Pulse stays high while the remaining count is above one.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            cnt_q <= '0;
            pulse <= 1'b0;
        end else if (start) begin
            cnt_q <= len;
            pulse <= (len != '0);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LEN_W'(1);
            pulse <= (cnt_q != LEN_W'(1));
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/dbg_mem_bridge.sv
// Executes decoded debug ops: CPU halt/resume/reset and waited memory accesses on NUM_CHAN channels.
module dbg_mem_bridge
    import dbg_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_CHAN     = 2,
    parameter int unsigned CHAN_W       = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned ADDR_STRIDE  = 1
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic                       op_valid,
    input  logic [7:0]                 op,
    input  logic [DATA_W-1:0]          op_data,
    output logic                       cpu_halt,
    output logic                       cpu_reset,
    output logic [NUM_CHAN-1:0]        mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [NUM_CHAN-1:0]        mem_ack,
    input  logic [NUM_CHAN*DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [STAT_W-1:0]          status
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);

    dbg_state_e          state_q, state_nxt;
    logic [TO_W-1:0]     to_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CHAN_W-1:0]   chan_q;
    logic                autoinc_q;
    logic                busy_q;
    logic                overrun_q, timeout_q, bad_chan_q;

    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic [NUM_CHAN-1:0] req_onehot;
    logic                chan_ok;
    logic                op_take, overrun_set, access_done, access_to;
    logic                clear_req, bad_set, reset_start;

    // Channel mux: selected ack, read data and one-hot request.
    always_comb begin
        ack_sel    = 1'b0;
        rdata_sel  = '0;
        req_onehot = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (chan_q == CHAN_W'(k)) begin
                ack_sel       = mem_ack[k];
                rdata_sel     = mem_rdata[k*DATA_W +: DATA_W];
                req_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt   = state_q;
        op_take     = 1'b0;
        overrun_set = 1'b0;
        access_done = 1'b0;
        access_to   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_take = 1'b1;
                    if (op == DBGOP_READ || op == DBGOP_WRITE) begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                overrun_set = op_valid;
                if (ack_sel) begin
                    access_done = 1'b1;
                    state_nxt   = S_DONE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    access_to = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                overrun_set = op_valid;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        chan_ok     = (32'(op_data[CHAN_W-1:0]) < NUM_CHAN);
        clear_req   = op_take && (op == DBGOP_CLEAR_STATUS);
        bad_set     = op_take && (op == DBGOP_SELECT_CHAN) && !chan_ok;
        reset_start = op_take && (op == DBGOP_RESET);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Datapath, handshake outputs and sticky flags; setting a flag wins over clearing it.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            to_cnt_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            chan_q     <= '0;
            autoinc_q  <= 1'b0;
            busy_q     <= 1'b0;
            cpu_halt   <= 1'b0;
            mem_req    <= '0;
            mem_we     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            bad_chan_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_ACCESS) ? to_cnt_q + TO_W'(1) : '0;
            mem_req  <= (state_nxt == S_ACCESS) ? req_onehot : '0;
            busy_q   <= (state_nxt != S_IDLE);
            rd_valid <= 1'b0;

            if (op_take) begin
                case (op)
                    DBGOP_HALT:        cpu_halt  <= 1'b1;
                    DBGOP_RESUME:      cpu_halt  <= 1'b0;
                    DBGOP_READ:        mem_we    <= 1'b0;
                    DBGOP_WRITE:       mem_we    <= 1'b1;
                    DBGOP_STORE_ADDR:  addr_q    <= op_data[ADDR_W-1:0];
                    DBGOP_STORE_DATA:  wdata_q   <= op_data;
                    DBGOP_STORE_FLAGS: autoinc_q <= op_data[0];
                    DBGOP_SELECT_CHAN: begin
                        if (chan_ok) begin
                            chan_q <= op_data[CHAN_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end

            if (access_done) begin
                if (!mem_we) begin
                    rd_data  <= rdata_sel;
                    rd_valid <= 1'b1;
                end
                if (autoinc_q) begin
                    addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
                end
            end

            overrun_q  <= (overrun_q  & ~clear_req) | overrun_set;
            timeout_q  <= (timeout_q  & ~clear_req) | access_to;
            bad_chan_q <= (bad_chan_q & ~clear_req) | bad_set;
        end
    end

    dbg_pulse_gen #(
        .LEN_W (RC_W)
    ) u_reset_pulse (
        .clk   (clk),
        .rst_p (rst_p),
        .start (reset_start),
        .len   (RC_W'(RESET_CYCLES)),
        .pulse (cpu_reset)
    );

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign status    = {3'b000, bad_chan_q, timeout_q, overrun_q, busy_q, cpu_halt};

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Bench for dbg_mem_bridge: behavioural model with per-cycle compare plus directed literal checks.
module tb_dbg_mem_bridge;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NUM_CHAN     = 2;
    localparam int unsigned CHAN_W       = 4;
    localparam int unsigned TIMEOUT      = 255;
    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned ADDR_STRIDE  = 1;

    logic                       clk = 1'b0;
    logic                       rst_p = 1'b1;
    logic                       op_valid = 1'b0;
    logic [7:0]                 op = 8'h00;
    logic [DATA_W-1:0]          op_data = '0;
    logic                       cpu_halt, cpu_reset;
    logic [NUM_CHAN-1:0]        mem_req;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [NUM_CHAN-1:0]        mem_ack = '0;
    logic [NUM_CHAN*DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_valid;
    logic [7:0]                 status;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    dbg_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W),
        .TIMEOUT(TIMEOUT), .RESET_CYCLES(RESET_CYCLES), .ADDR_STRIDE(ADDR_STRIDE)
    ) dut (
        .clk(clk), .rst_p(rst_p), .op_valid(op_valid), .op(op), .op_data(op_data),
        .cpu_halt(cpu_halt), .cpu_reset(cpu_reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must be after each clock edge.
    logic              m_halt = 0, m_we = 0, m_autoinc = 0, m_acc = 0, m_done = 0;
    logic              m_ovr = 0, m_to = 0, m_bad = 0, m_rdv = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rdd = '0;
    int                m_chan = 0, m_wait = 0, m_rst_left = 0;

    always @(posedge clk) begin
        logic was_busy;
        if (rst_p) begin
            m_halt = 0; m_we = 0; m_autoinc = 0; m_acc = 0; m_done = 0;
            m_ovr = 0; m_to = 0; m_bad = 0; m_rdv = 0;
            m_addr = '0; m_wdata = '0; m_rdd = '0;
            m_chan = 0; m_wait = 0; m_rst_left = 0;
        end else begin
            was_busy = m_acc || m_done;
            m_rdv  = 0;
            m_done = 0;
            if (m_rst_left > 0) m_rst_left--;
            if (m_acc) begin
                if (mem_ack[m_chan]) begin
                    m_acc = 0; m_done = 1;
                    if (!m_we) begin
                        m_rdd = mem_rdata[m_chan*DATA_W +: DATA_W];
                        m_rdv = 1;
                    end
                    if (m_autoinc) m_addr = m_addr + ADDR_W'(ADDR_STRIDE);
                end else begin
                    m_wait++;
                    if (m_wait >= int'(TIMEOUT)) begin
                        m_acc = 0; m_done = 1; m_to = 1;
                    end
                end
            end
            if (op_valid) begin
                if (was_busy) m_ovr = 1;
                else case (op)
                    8'h01: m_halt = 1;
                    8'h02: m_halt = 0;
                    8'h03: m_rst_left = RESET_CYCLES;
                    8'h04: begin m_acc = 1; m_wait = 0; m_we = 0; end
                    8'h05: begin m_acc = 1; m_wait = 0; m_we = 1; end
                    8'h08: begin m_ovr = 0; m_to = 0; m_bad = 0; end
                    8'h80: m_addr = op_data[ADDR_W-1:0];
                    8'h81: m_wdata = op_data;
                    8'h82: if (int'(op_data[CHAN_W-1:0]) < NUM_CHAN) m_chan = int'(op_data[CHAN_W-1:0]);
                           else m_bad = 1;
                    8'h84: m_autoinc = op_data[0];
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [NUM_CHAN-1:0] exp_req;
        logic [7:0]          exp_status;
        if (cmp_en) begin
            exp_req    = m_acc ? NUM_CHAN'(1) << m_chan : '0;
            exp_status = {3'b000, m_bad, m_to, m_ovr, (m_acc || m_done), m_halt};
            chk("cyc_cpu_halt", 64'(cpu_halt), 64'(m_halt));
            chk("cyc_cpu_reset", 64'(cpu_reset), 64'(m_rst_left > 0));
            chk("cyc_mem_req", 64'(mem_req), 64'(exp_req));
            if (exp_req != '0) chk("cyc_mem_we", 64'(mem_we), 64'(m_we));
            chk("cyc_mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("cyc_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("cyc_rd_valid", 64'(rd_valid), 64'(m_rdv));
            chk("cyc_rd_data", 64'(rd_data), 64'(m_rdd));
            chk("cyc_status", 64'(status), 64'(exp_status));
        end
    end

    task automatic issue_op(input logic [7:0] o, input logic [DATA_W-1:0] d);
        @(negedge clk);
        op_valid = 1'b1; op = o; op_data = d;
        @(negedge clk);
        op_valid = 1'b0; op = 8'h00; op_data = '0;
    endtask

    // Follows one access: acks during request cycle ack_after+1 (never if negative).
    task automatic run_access(input int ack_after, output int n, output logic got_v,
                              output logic [DATA_W-1:0] got_d, output logic [NUM_CHAN-1:0] req_seen,
                              output logic we_seen, output logic [ADDR_W-1:0] addr_seen);
        n = 0; got_v = 0; got_d = '0; req_seen = '0; we_seen = 0; addr_seen = '0;
        for (int g = 0; g < 400; g++) begin
            if (mem_req != '0) begin
                if (n == 0) begin
                    req_seen = mem_req; we_seen = mem_we; addr_seen = mem_addr;
                end
                n++;
                if (n == ack_after + 1) mem_ack = mem_req;
            end else if (n > 0) begin
                got_v = rd_valid; got_d = rd_data;
                mem_ack = '0;
                return;
            end
            @(negedge clk);
        end
        mem_ack = '0;
        checks++; errors++;
        $display("FAIL access_bound: access did not finish within 400 cycles, req cycles %0d", n);
    endtask

    initial begin
        int                  n;
        logic                v, we;
        logic [DATA_W-1:0]   d;
        logic [NUM_CHAN-1:0] rq;
        logic [ADDR_W-1:0]   a;

        repeat (3) @(negedge clk);
        rst_p = 1'b0;
        cmp_en = 1'b1;
        chk("reset_status", 64'(status), 64'h00);
        chk("reset_mem_req", 64'(mem_req), 64'h0);

        issue_op(8'h01, '0);
        chk("halt", 64'(cpu_halt), 64'h1);
        chk("halt_status", 64'(status), 64'h01);
        issue_op(8'h02, '0);
        chk("resume", 64'(cpu_halt), 64'h0);

        // Write on channel 1, ack after 3 request cycles.
        issue_op(8'h80, 32'h0000_0010);
        issue_op(8'h81, 32'hDEAD_BEEF);
        issue_op(8'h82, 32'h1);
        issue_op(8'h05, '0);
        run_access(3, n, v, d, rq, we, a);
        chk("wr_req_cycles", 64'(n), 64'd4);
        chk("wr_req_vec", 64'(rq), 64'h2);
        chk("wr_we", 64'(we), 64'h1);
        chk("wr_addr", 64'(a), 64'h0010);
        chk("wr_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("wr_no_rdvalid", 64'(v), 64'h0);

        // Auto-increment reads on channel 0 across the address wrap.
        issue_op(8'h84, 32'h1);
        issue_op(8'h80, 32'h0000_FFFF);
        issue_op(8'h82, 32'h0);
        mem_rdata = {32'h0000_0000, 32'h0000_0011};
        issue_op(8'h04, '0);
        run_access(1, n, v, d, rq, we, a);
        chk("rd1_valid", 64'(v), 64'h1);
        chk("rd1_data", 64'(d), 64'h11);
        chk("rd1_addr", 64'(a), 64'hFFFF);
        mem_rdata = {32'h0000_0000, 32'h0000_0022};
        issue_op(8'h04, '0);
        run_access(0, n, v, d, rq, we, a);
        chk("rd2_valid", 64'(v), 64'h1);
        chk("rd2_data", 64'(d), 64'h22);
        chk("rd2_addr", 64'(a), 64'h0000);

        // Unacknowledged read times out.
        issue_op(8'h04, '0);
        run_access(-1, n, v, d, rq, we, a);
        chk("to_req_cycles", 64'(n), 64'd255);
        chk("to_no_rdvalid", 64'(v), 64'h0);
        @(negedge clk);
        chk("to_status", 64'(status), 64'h08);
        chk("to_no_autoinc", 64'(mem_addr), 64'h0001);
        issue_op(8'h08, '0);
        chk("clear_status", 64'(status), 64'h00);

        // Out-of-range channel select leaves the channel alone.
        issue_op(8'h82, 32'h5);
        chk("bad_chan_status", 64'(status), 64'h10);
        issue_op(8'h04, '0);
        issue_op(8'h01, '0);
        run_access(0, n, v, d, rq, we, a);
        chk("bad_chan_keeps_ch0", 64'(rq), 64'h1);
        @(negedge clk);
        chk("overrun_status", 64'(status), 64'h14);
        chk("overrun_dropped_halt", 64'(cpu_halt), 64'h0);

        // CPU reset pulse length.
        issue_op(8'h03, '0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (cpu_reset) n++;
            @(negedge clk);
        end
        chk("reset_pulse_len", 64'(n), 64'd4);

        // Synchronous reset in the middle of an access.
        issue_op(8'h04, '0);
        chk("pre_rst_req", 64'(mem_req), 64'h1);
        rst_p = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 64'(mem_req), 64'h0);
        chk("rst_mid_status", 64'(status), 64'h00);
        rst_p = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
